lif_neuron_scheduler: RTL

Time-multiplexed controller that sequences one shared leaky-integrate-and-fire (LIF) update datapath across NEURONS virtual neurons. It holds per-neuron membrane and refractory state, the shared neuron configuration registers, and the per-timestep update FSM. It sits between the top-level pin mapping (ui_in/uio_in/uo_out) and the LIF arithmetic.

---
 rtl/lif_neuron_scheduler_pkg.sv | 23 ++
 rtl/lif_neuron_scheduler_if.sv | 27 ++
 rtl/lif_neuron_scheduler_update.sv | 44 ++++
 rtl/lif_neuron_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared constants and types for the time-multiplexed LIF neuron scheduler.
// Holds the config address map, the config reset values and the FSM state encoding.
package lif_pkg;

    localparam logic [1:0] CFG_THRESH = 2'd0;
    localparam logic [1:0] CFG_LEAK   = 2'd1;
    localparam logic [1:0] CFG_REFR   = 2'd2;
    localparam logic [1:0] CFG_MODE   = 2'd3;

    localparam logic [7:0] THRESH_RST = 8'd128;
    localparam logic [2:0] LEAK_RST   = 3'd1;
    localparam logic [3:0] REFR_RST   = 4'd0;
    localparam logic       MODE_RST   = 1'b0;

    localparam int REF_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/lif_neuron_scheduler_if.sv
// Config/step/spike bundle between the pin mapping and the LIF scheduler.
// master drives config writes, step and currents; slave returns status and spikes.
interface lif_neuron_scheduler_if #(
    parameter int NEURONS = 4,
    parameter int IN_W    = 8
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [1:0]                cfg_addr;
    logic [7:0]                cfg_data;
    logic                      step;
    logic [NEURONS*IN_W-1:0]   in_current;
    logic                      busy;
    logic [NEURONS-1:0]        spikes;
    logic                      spike_valid;
    logic                      overrun;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, step, in_current,
        input  cfg_ready, busy, spikes, spike_valid, overrun
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, step, in_current,
        output cfg_ready, busy, spikes, spike_valid, overrun
    );
endinterface

// File: rtl/lif_neuron_scheduler_update.sv
// Combinational single-neuron LIF update: leak, saturating integrate, threshold, reset/subtract.
// Refractory ports exist only when LIF_REFRACTORY_EN is defined.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int STATE_W = 8,
    parameter int IN_W    = 8
) (
    input  logic [STATE_W-1:0] i_u,
    input  logic [STATE_W-1:0] i_thresh,
    input  logic [IN_W-1:0]    i_cur,
    input  logic [2:0]         i_leak,
    input  logic               i_mode,
`ifdef LIF_REFRACTORY_EN
    input  logic [REF_W-1:0]   i_ref,
    input  logic [REF_W-1:0]   i_refr_len,
    output logic [REF_W-1:0]   o_ref,
`endif
    output logic [STATE_W-1:0] o_u,
    output logic               o_spike
);

    logic [STATE_W-1:0] w_leaked;
    logic [STATE_W:0]   w_sum;
    logic [STATE_W-1:0] w_sat;

    always_comb begin
        w_leaked = (i_leak == 3'd0) ? i_u : (i_u - (i_u >> i_leak));
        w_sum    = {1'b0, w_leaked} + {{(STATE_W + 1 - IN_W){1'b0}}, i_cur};
        w_sat    = w_sum[STATE_W] ? {STATE_W{1'b1}} : w_sum[STATE_W-1:0];
        o_spike  = (w_sat >= i_thresh);
        o_u      = o_spike ? (i_mode ? (w_sat - i_thresh) : '0) : w_sat;
`ifdef LIF_REFRACTORY_EN
        o_ref    = o_spike ? i_refr_len : i_ref;
        // A refractory neuron neither integrates nor fires; it only counts down.
        if (i_ref != '0) begin
            o_u     = '0;
            o_spike = 1'b0;
            o_ref   = i_ref - 1'b1;
        end
`endif
    end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Sequences one shared LIF update unit over NEURONS virtual neurons; latency NEURONS+2 cycles per step.
// step while busy is dropped and flags overrun; ena low freezes all state. Optional: LIF_REFRACTORY_EN.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int NEURONS = 4,
    parameter int STATE_W = 8,
    parameter int IN_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    lif_neuron_scheduler_if.slave  bus
);

    localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [NEURONS*IN_W-1:0]  r_cur;
    logic [STATE_W-1:0]       r_u [NEURONS];
    logic [NEURONS-1:0]       r_acc;
    logic [NEURONS-1:0]       r_spikes;
    logic                     r_overrun;
    logic [STATE_W-1:0]       r_thresh;
    logic [2:0]               r_leak;
    logic                     r_mode;
`ifdef LIF_REFRACTORY_EN
    logic [REF_W-1:0]         r_ref [NEURONS];
    logic [REF_W-1:0]         r_refr_len;
    logic [REF_W-1:0]         w_ref_nxt;
`endif

    logic                     w_step_go;
    logic                     w_cfg_we;
    logic                     w_last;
    logic [STATE_W-1:0]       w_u_nxt;
    logic                     w_spike;
    logic [NEURONS-1:0]       w_spk_vec;

    assign w_step_go = ena && bus.step && (r_state == S_IDLE);
    assign w_cfg_we  = ena && bus.cfg_valid && (r_state == S_IDLE);
    assign w_last    = (r_idx == IDX_W'(NEURONS - 1));

    assign bus.cfg_ready   = ena && (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.spike_valid = ena && (r_state == S_DONE);
    assign bus.spikes      = r_spikes;
    assign bus.overrun     = r_overrun;

    lif_update_unit #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W)
    ) u_update (
        .i_u        (r_u[r_idx]),
        .i_thresh   (r_thresh),
        .i_cur      (r_cur[r_idx*IN_W +: IN_W]),
        .i_leak     (r_leak),
        .i_mode     (r_mode),
`ifdef LIF_REFRACTORY_EN
        .i_ref      (r_ref[r_idx]),
        .i_refr_len (r_refr_len),
        .o_ref      (w_ref_nxt),
`endif
        .o_u        (w_u_nxt),
        .o_spike    (w_spike)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_spk_vec   = r_acc;
        w_spk_vec[r_idx] = w_spike;
        case (r_state)
            S_IDLE:   if (w_step_go) w_state_nxt = S_UPDATE;
            S_UPDATE: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_cur     <= '0;
            r_acc     <= '0;
            r_spikes  <= '0;
            r_overrun <= 1'b0;
            r_thresh  <= STATE_W'(THRESH_RST);
            r_leak    <= LEAK_RST;
            r_mode    <= MODE_RST;
            for (int i = 0; i < NEURONS; i++) begin
                r_u[i] <= '0;
`ifdef LIF_REFRACTORY_EN
                r_ref[i] <= '0;
`endif
            end
`ifdef LIF_REFRACTORY_EN
            r_refr_len <= REFR_RST;
`endif
        end else if (ena) begin
            if (w_cfg_we) begin
                case (bus.cfg_addr)
                    CFG_THRESH: r_thresh <= STATE_W'(bus.cfg_data);
                    CFG_LEAK:   r_leak   <= bus.cfg_data[2:0];
`ifdef LIF_REFRACTORY_EN
                    CFG_REFR:   r_refr_len <= bus.cfg_data[3:0];
`else
                    CFG_REFR:   ;
`endif
                    CFG_MODE:   r_mode   <= bus.cfg_data[0];
                    default:    ;
                endcase
            end
            if (bus.step && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            // Currents are captured once so mid-step input changes cannot leak in.
            if (w_step_go) begin
                r_cur <= bus.in_current;
                r_idx <= '0;
                r_acc <= '0;
            end
            if (r_state == S_UPDATE) begin
                r_u[r_idx] <= w_u_nxt;
`ifdef LIF_REFRACTORY_EN
                r_ref[r_idx] <= w_ref_nxt;
`endif
                r_acc <= w_spk_vec;
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    r_spikes <= w_spk_vec;
                end
            end
        end
    end

endmodule
